// File: rtl/alu_seq_md_pkg.sv
// Shared op codes, FSM states and decode helpers for the execute-stage ALU.
// Ports: none (package only).
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'b00000,
        OP_SUB    = 5'b00001,
        OP_AND    = 5'b00010,
        OP_OR     = 5'b00011,
        OP_PASSB  = 5'b00100,
        OP_XOR    = 5'b00101,
        OP_SLT    = 5'b00110,
        OP_SRL    = 5'b00111,
        OP_SRA    = 5'b01000,
        OP_SLTU   = 5'b01001,
        OP_SLL    = 5'b01010,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Unassigned codes fall back to ADD.
    function automatic alu_op_e decode_op(input logic [4:0] code);
        if (code <= 5'd10 || code[4:3] == 2'b10)
            return alu_op_e'(code);
        return OP_ADD;
    endfunction

    function automatic logic is_muldiv(input alu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                          OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/alu_seq_md_if.sv
// Operand/result valid-ready bundle between the issue logic and the ALU.
// master drives operands and out_ready; slave returns in_ready and results.
interface alu_seq_md_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4:0]            ALUControl;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  Zero;

    modport master (
        output in_valid, ALUControl, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero
    );

    modport slave (
        input  in_valid, ALUControl, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero
    );
endinterface

// File: rtl/alu_seq_md_muldiv.sv
// Iterative radix-2 multiply / restoring divide engine for the M group.
// Ports: clk, rst, start/op/a/b (latched on start), busy, done (1 cycle), result.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  alu_op_e               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    state_e        state, state_n;
    logic [CW-1:0] cnt;
    alu_op_e       op_q;
    logic          qneg, rneg;
    logic [W-1:0]  hi, lo, opd, res;

    logic          signed_a, signed_b, sa, sb, start_div;
    logic [W-1:0]  a_mag, b_mag;
    logic          div_q, rem_q;
    logic [W:0]    sum, shifted;
    logic          ok;
    logic [W-1:0]  mul_hi, mul_lo, div_hi, div_lo, sub;
    logic [2*W-1:0] prod, prod_s;
    logic [W-1:0]  quo, rem, fix_res;

    assign signed_a  = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign signed_b  = op inside {OP_MULH, OP_DIV, OP_REM};
    assign sa        = signed_a && a[W-1];
    assign sb        = signed_b && b[W-1];
    assign a_mag     = sa ? -a : a;
    assign b_mag     = sb ? -b : b;
    assign start_div = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    assign div_q = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign rem_q = op_q inside {OP_REM, OP_REMU};

    // Multiply: {hi,lo} shifts right, multiplicand added into hi.
    assign sum    = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    assign mul_hi = sum[W:1];
    assign mul_lo = {sum[0], lo[W-1:1]};

    // Divide: remainder in hi, dividend shifts out of lo, quotient in.
    // The true difference is < divisor, so W bits suffice.
    assign shifted = {hi, lo[W-1]};
    assign ok      = shifted >= {1'b0, opd};
    assign sub     = shifted[W-1:0] - opd;
    assign div_hi  = ok ? sub : shifted[W-1:0];
    assign div_lo  = {lo[W-2:0], ok};

    assign prod    = {hi, lo};
    assign prod_s  = qneg ? -prod : prod;
    assign quo     = qneg ? -lo : lo;
    assign rem     = rneg ? -hi : hi;

    always_comb begin
        fix_res = prod_s[2*W-1:W];
        if (div_q)
            fix_res = rem_q ? rem : quo;
        else if (op_q == OP_MUL)
            fix_res = prod_s[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = BUSY;
            BUSY:    if (cnt == CW'(W)) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            op_q <= OP_MUL;
            qneg <= 1'b0;
            rneg <= 1'b0;
            hi   <= '0;
            lo   <= '0;
            opd  <= '0;
            res  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q <= op;
                    // Zero divisor keeps the all-ones quotient unsigned.
                    qneg <= (sa ^ sb) && (b != '0);
                    rneg <= sa;
                    cnt  <= '0;
                    hi   <= '0;
                    lo   <= start_div ? a_mag : b_mag;
                    opd  <= start_div ? b_mag : a_mag;
                end
                BUSY: if (cnt != CW'(W)) begin
                    cnt <= cnt + 1'b1;
                    hi  <= div_q ? div_hi : mul_hi;
                    lo  <= div_q ? div_lo : mul_lo;
                end else begin
                    res <= fix_res;
                end
                default: ;
            endcase
        end
    end

    assign busy   = state != IDLE;
    assign done   = state == FIX;
    assign result = res;

endmodule

// File: rtl/alu_seq_md.sv
// Registered execute-stage ALU: single-cycle simple ops plus iterative M group.
// Ports: clk, rst, bus (slave: operands in, result out, valid/ready), busy.
module alu_seq_md
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic        clk,
    input  logic        rst,
    alu_seq_md_if.slave bus,
    output logic        busy
);
    localparam int W = DATA_WIDTH;

    alu_op_e            op;
    logic [W-1:0]       a, b, simple, md_res, res_q;
    logic [SHAMT_W-1:0] shamt;
    logic               accept, md_start, md_done, md_busy;
    logic               out_valid_q, zero_q;

    assign op    = decode_op(bus.ALUControl);
    assign a     = bus.SrcA;
    assign b     = bus.SrcB;
    assign shamt = b[SHAMT_W-1:0];

    // No accept while iterating or while a result is stuck downstream.
    assign bus.in_ready = !md_busy && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign md_start     = accept && is_muldiv(op);

    always_comb begin
        simple = a + b;
        case (op)
            OP_SUB:   simple = a - b;
            OP_AND:   simple = a & b;
            OP_OR:    simple = a | b;
            OP_PASSB: simple = b;
            OP_XOR:   simple = a ^ b;
            OP_SLT:   simple = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SRL:   simple = a >> shamt;
            OP_SRA:   simple = W'($signed(a) >>> shamt);
            OP_SLTU:  simple = {{(W-1){1'b0}}, a < b};
            OP_SLL:   simple = a << shamt;
            default:  simple = a + b;
        endcase
    end

    muldiv_iter #(.DATA_WIDTH(W)) u_md (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
        end else if (accept && !is_muldiv(op)) begin
            out_valid_q <= 1'b1;
            res_q       <= simple;
            zero_q      <= simple == '0;
        end else if (md_done) begin
            out_valid_q <= 1'b1;
            res_q       <= md_res;
            zero_q      <= md_res == '0;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.ALUResult = res_q;
    assign bus.Zero      = zero_q;
    assign busy          = md_busy;

endmodule
